// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter for four cache controllers that runs one
//            snooping-bus transaction per grant (snoop, memory latency, done).
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NUM_PROCS = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [7:0]   req_type,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_value,
  input  logic [3:0]   shared_in,
  output logic [3:0]   grant,
  output logic [3:0]   done,
  output logic [1:0]   proc_ID,
  output logic [31:0]  address,
  output logic [31:0]  value,
  output logic         RdMs,
  output logic         WrMs,
  output logic         WrBk,
  output logic         shared
);

  localparam logic [1:0] c_s_idle  = 2'd0;
  localparam logic [1:0] c_s_snoop = 2'd1;
  localparam logic [1:0] c_s_xfer  = 2'd2;
  localparam logic [1:0] c_s_done  = 2'd3;

  logic [1:0]  r_state, w_state_nxt;
  logic [1:0]  r_ptr, w_ptr_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_grant, w_grant_nxt;
  logic [3:0]  r_done, w_done_nxt;
  logic [1:0]  r_proc_id, w_proc_id_nxt;
  logic [31:0] r_address, w_address_nxt;
  logic [31:0] r_value, w_value_nxt;
  logic        r_rdms, w_rdms_nxt;
  logic        r_wrms, w_wrms_nxt;
  logic        r_wrbk, w_wrbk_nxt;
  logic        r_shared, w_shared_nxt;

  logic [3:0]  w_eligible;
  logic        w_found;
  logic [1:0]  w_win;
  logic [1:0]  w_win_type;

  // Illegal type 11 makes a core invisible to arbitration.
  for (genvar i = 0; i < NUM_PROCS; i++) begin : g_elig
    assign w_eligible[i] = req[i] && (req_type[2*i+1 -: 2] != 2'b11);
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 0; k < NUM_PROCS; k++) begin
      if (!w_found && w_eligible[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(k);
      end
    end
  end

  assign w_win_type = req_type[{w_win, 1'b0} +: 2];

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_s_idle;
      r_ptr     <= 2'd0;
      r_cnt     <= 4'd0;
      r_grant   <= 4'd0;
      r_done    <= 4'd0;
      r_proc_id <= 2'd0;
      r_address <= 32'd0;
      r_value   <= 32'd0;
      r_rdms    <= 1'b0;
      r_wrms    <= 1'b0;
      r_wrbk    <= 1'b0;
      r_shared  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_proc_id <= w_proc_id_nxt;
      r_address <= w_address_nxt;
      r_value   <= w_value_nxt;
      r_rdms    <= w_rdms_nxt;
      r_wrms    <= w_wrms_nxt;
      r_wrbk    <= w_wrbk_nxt;
      r_shared  <= w_shared_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_idle:  if (w_found) w_state_nxt = c_s_snoop;
      c_s_snoop: w_state_nxt = c_s_xfer;
      c_s_xfer:  if (r_cnt == 4'd0) w_state_nxt = c_s_done;
      default:   w_state_nxt = c_s_idle;
    endcase
  end

  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_done_nxt    = r_done;
    w_proc_id_nxt = r_proc_id;
    w_address_nxt = r_address;
    w_value_nxt   = r_value;
    w_rdms_nxt    = r_rdms;
    w_wrms_nxt    = r_wrms;
    w_wrbk_nxt    = r_wrbk;
    w_shared_nxt  = r_shared;
    case (r_state)
      c_s_idle: begin
        if (w_found) begin
          w_ptr_nxt     = w_win + 2'd1;
          w_grant_nxt   = 4'b0001 << w_win;
          w_proc_id_nxt = w_win;
          w_address_nxt = req_addr[{w_win, 5'd0} +: 32];
          w_value_nxt   = req_value[{w_win, 5'd0} +: 32];
          w_rdms_nxt    = (w_win_type == 2'b00);
          w_wrms_nxt    = (w_win_type == 2'b01);
          w_wrbk_nxt    = (w_win_type == 2'b10);
        end
      end
      c_s_snoop: begin
        // The owner's own snoop response is not a sharer.
        w_shared_nxt = |(shared_in & ~r_grant);
        w_cnt_nxt    = 4'(MEM_LAT - 1);
      end
      c_s_xfer: begin
        if (r_cnt == 4'd0) begin
          w_done_nxt = r_grant;
          w_rdms_nxt = 1'b0;
          w_wrms_nxt = 1'b0;
          w_wrbk_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_grant_nxt   = 4'd0;
        w_done_nxt    = 4'd0;
        w_shared_nxt  = 1'b0;
        w_proc_id_nxt = 2'd0;
        w_address_nxt = 32'd0;
        w_value_nxt   = 32'd0;
      end
    endcase
  end

  assign grant   = r_grant;
  assign done    = r_done;
  assign proc_ID = r_proc_id;
  assign address = r_address;
  assign value   = r_value;
  assign RdMs    = r_rdms;
  assign WrMs    = r_wrms;
  assign WrBk    = r_wrbk;
  assign shared  = r_shared;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed stimulus with a transaction scoreboard for bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int c_mem_lat = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [7:0]   req_type;
  logic [127:0] req_addr;
  logic [127:0] req_value;
  logic [3:0]   shared_in;
  logic [3:0]   grant;
  logic [3:0]   done;
  logic [1:0]   proc_ID;
  logic [31:0]  address;
  logic [31:0]  value;
  logic         RdMs;
  logic         WrMs;
  logic         WrBk;
  logic         shared;

  bus_arbiter #(.NUM_PROCS(4), .MEM_LAT(c_mem_lat)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_type(req_type),
    .req_addr(req_addr), .req_value(req_value), .shared_in(shared_in),
    .grant(grant), .done(done), .proc_ID(proc_ID), .address(address),
    .value(value), .RdMs(RdMs), .WrMs(WrMs), .WrBk(WrBk), .shared(shared)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [2:0]  cmd;     // {RdMs, WrMs, WrBk}
    logic [31:0] addr;
    logic [31:0] val;
    logic        shrd;
    int          lat;     // cycles from issue to done, -1 = unchecked
    int          push_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accumulates what the bus showed while busy, scores on done.
  int          busy = 0;
  logic [2:0]  obs_cmd;
  logic [1:0]  obs_proc;
  logic [31:0] obs_addr, obs_val;
  logic        obs_shrd;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
    end else if (grant == 4'd0 && done == 4'd0) begin
      busy = 0;
      chk("idle_outputs", {proc_ID, address, value, RdMs, WrMs, WrBk, shared}, '0);
    end else if (done == 4'd0) begin
      busy++;
      chk("cmd_onehot", 64'($countones({RdMs, WrMs, WrBk})), 64'd1);
      if (busy == 1) begin
        obs_cmd  = {RdMs, WrMs, WrBk};
        obs_proc = proc_ID;
        obs_addr = address;
        obs_val  = value;
      end else begin
        chk("bus_stable", {obs_cmd, obs_proc, obs_addr}, {RdMs, WrMs, WrBk, proc_ID, address});
      end
      if (busy == 2) obs_shrd = shared;
      else if (busy > 2) chk("shared_stable", 64'(shared), 64'(obs_shrd));
    end else begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done", 64'(done), 64'(4'b0001 << e.core));
        chk("grant_in_done", 64'(grant), 64'(4'b0001 << e.core));
        chk("cmd_in_done", 64'({RdMs, WrMs, WrBk}), 64'd0);
        chk("proc_ID", 64'(obs_proc), 64'(e.core));
        chk("cmd", 64'(obs_cmd), 64'(e.cmd));
        chk("address", 64'(obs_addr), 64'(e.addr));
        chk("value", 64'(obs_val), 64'(e.val));
        chk("shared", 64'(obs_shrd), 64'(e.shrd));
        chk("busy_cycles", 64'(busy), 64'(1 + c_mem_lat));
        if (e.lat >= 0) chk("latency", 64'(cyc - e.push_cyc), 64'(e.lat));
      end
    end
  end

  task automatic expect_txn(input int core, input logic [2:0] cmd, input logic [31:0] a,
                            input logic [31:0] v, input logic s, input int lat);
    exp_t e;
    e.core = core; e.cmd = cmd; e.addr = a; e.val = v; e.shrd = s;
    e.lat = lat; e.push_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] v);
    req_type[2*i +: 2]   = t;
    req_addr[32*i +: 32] = a;
    req_value[32*i +: 32] = v;
    req[i] = 1'b1;
  endtask

  // Requesters drop req when they see done; waits until all cores in mask are served.
  task automatic wait_served(input logic [3:0] mask);
    int n;
    n = 0;
    while ((req & mask) != 4'd0 && n < 100) begin
      @(negedge clk);
      req = req & ~done;
      n++;
    end
    if ((req & mask) != 4'd0) begin
      errors++;
      $display("FAIL timeout: req %0h still pending", req & mask);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_type = '0; req_addr = '0; req_value = '0; shared_in = '0;
    do_reset();

    // 1: single read miss from core 2
    set_req(2, 2'b00, 32'h0000_0100, 32'h0);
    expect_txn(2, 3'b100, 32'h100, 32'h0, 1'b0, 4);
    wait_served(4'b0100);

    // 2: all four request from reset, served 0..3 with one idle gap each
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 32'h1000 + 32'(i), 32'h0);
    for (int i = 0; i < 4; i++) expect_txn(i, 3'b100, 32'h1000 + 32'(i), 32'h0, 1'b0, 4 + 5 * i);
    wait_served(4'b1111);

    // 3: write miss, sharer present then only the owner's own bit
    shared_in = 4'b1000;
    set_req(1, 2'b01, 32'h40, 32'h0);
    expect_txn(1, 3'b010, 32'h40, 32'h0, 1'b1, 4);
    wait_served(4'b0010);
    shared_in = 4'b0010;
    set_req(1, 2'b01, 32'h40, 32'h0);
    expect_txn(1, 3'b010, 32'h40, 32'h0, 1'b0, 4);
    wait_served(4'b0010);
    shared_in = 4'b0000;

    // 4: writeback with data
    set_req(3, 2'b10, 32'h80, 32'hDEAD_BEEF);
    expect_txn(3, 3'b001, 32'h80, 32'hDEAD_BEEF, 1'b0, 4);
    wait_served(4'b1000);

    // 5: illegal request from core 0 is never granted and never blocks
    set_req(0, 2'b11, 32'h55, 32'h0);
    repeat (10) @(negedge clk);
    set_req(1, 2'b00, 32'h44, 32'h0);
    expect_txn(1, 3'b100, 32'h44, 32'h0, 1'b0, 4);
    wait_served(4'b0010);
    req = '0;
    @(negedge clk);

    // 6: reset during XFER abandons core 2; pointer restarts at core 0
    set_req(0, 2'b00, 32'h10, 32'h0);
    set_req(2, 2'b01, 32'h20, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_txn(0, 3'b100, 32'h10, 32'h0, 1'b0, 4);
    expect_txn(2, 3'b010, 32'h20, 32'h0, 1'b0, 9);
    wait_served(4'b0101);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
